// File: rtl/regfile.sv
// regfile: architectural integer register file at the writeback end of the
// pipeline, with two bypassed read ports and a per-register pending scoreboard.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   we/waddr/wdata    writeback commit from MEM/WB (writes to x0 dropped)
//   re1/raddr1        read port 1 enable/index -> rdata1, pend1
//   re2/raddr2        read port 2 enable/index -> rdata2, pend2
//   pend_set/pend_addr  mark a destination as having an outstanding producer
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              pend1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              pend2,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic              wr_en;
    logic              hit1;
    logic              hit2;

    assign wr_en = we && (waddr != '0);

    // Clear first, then set: a new producer issued in the same cycle as an
    // older one retiring to the same register keeps the entry pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[waddr] = 1'b0;
        end
        if (pend_set && (pend_addr != '0)) begin
            pend_d[pend_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[waddr] <= wdata;
            end
            pend_q <= pend_d;
        end
    end

    // Same-cycle writeback match; x0 never matches because wr_en excludes it.
    assign hit1 = wr_en && (waddr == raddr1);
    assign hit2 = wr_en && (waddr == raddr2);

    always_comb begin
        rdata1 = '0;
        pend1  = 1'b0;
        if (!rst && re1 && (raddr1 != '0)) begin
            rdata1 = hit1 ? wdata : regs_q[raddr1];
            pend1  = pend_q[raddr1] && !hit1;
        end
    end

    always_comb begin
        rdata2 = '0;
        pend2  = 1'b0;
        if (!rst && re2 && (raddr2 != '0)) begin
            rdata2 = hit2 ? wdata : regs_q[raddr2];
            pend2  = pend_q[raddr2] && !hit2;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed bench for regfile covering reset, x0, bypass,
// dual read, scoreboard set/clear and set/clear collision.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        pend1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        pend2;
    logic        pend_set;
    logic [4:0]  pend_addr;

    int errors = 0;
    int checks = 0;

    regfile dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .pend1     (pend1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .pend2     (pend2),
        .pend_set  (pend_set),
        .pend_addr (pend_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        pend_set = 1'b0; pend_addr = '0;
        step();
        // Outputs forced low during reset even with a bypassing write.
        we = 1'b1; waddr = 5'd5; wdata = 32'hCAFE_F00D;
        re1 = 1'b1; raddr1 = 5'd5;
        settle();
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_pend1", {31'b0, pend1}, 32'h0);
        step();

        // T1 reset: write x5 and mark it pending, then reset.
        rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        pend_set = 1'b1; pend_addr = 5'd5; re1 = 1'b0;
        step();
        we = 1'b0; pend_set = 1'b0; re2 = 1'b1; raddr2 = 5'd5;
        settle();
        chk("t1_pre_rdata2", rdata2, 32'hDEAD_BEEF);
        chk("t1_pre_pend2", {31'b0, pend2}, 32'h1);
        rst = 1'b1;
        settle();
        chk("t1_in_rst_rdata2", rdata2, 32'h0);
        step();
        rst = 1'b0;
        settle();
        chk("t1_post_rdata2", rdata2, 32'h0);
        chk("t1_post_pend2", {31'b0, pend2}, 32'h0);

        // T2 x0 writes dropped, x0 never pending.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        settle();
        chk("t2_nobypass_x0", rdata1, 32'h0);
        step();
        we = 1'b0;
        settle();
        chk("t2_rdata1_x0", rdata1, 32'h0);
        chk("t2_rdata2_x0", rdata2, 32'h0);
        pend_set = 1'b1; pend_addr = 5'd0;
        step();
        pend_set = 1'b0;
        settle();
        chk("t2_pend1_x0", {31'b0, pend1}, 32'h0);

        // T3 same-cycle bypass, then registered value, then disabled port.
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
        settle();
        chk("t3_bypass", rdata1, 32'h1234_5678);
        chk("t3_re2_off", rdata2, 32'h0);
        step();
        we = 1'b0;
        settle();
        chk("t3_stored", rdata1, 32'h1234_5678);
        re1 = 1'b0; re2 = 1'b1;
        settle();
        chk("t3_re1_off", rdata1, 32'h0);
        chk("t3_port2", rdata2, 32'h1234_5678);

        // T4 dual read.
        we = 1'b1; waddr = 5'd1; wdata = 32'h11;
        step();
        waddr = 5'd2; wdata = 32'h22;
        step();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd2; re2 = 1'b1; raddr2 = 5'd1;
        settle();
        chk("t4_r1_x2", rdata1, 32'h22);
        chk("t4_r2_x1", rdata2, 32'h11);
        raddr1 = 5'd1;
        settle();
        chk("t4_same_r1", rdata1, 32'h11);
        chk("t4_same_r2", rdata2, 32'h11);

        // T5 scoreboard set and combinational clear.
        pend_set = 1'b1; pend_addr = 5'd9;
        step();
        pend_set = 1'b0; raddr1 = 5'd9; re2 = 1'b0; raddr2 = 5'd9;
        settle();
        chk("t5_pend1_set", {31'b0, pend1}, 32'h1);
        chk("t5_pend2_re_off", {31'b0, pend2}, 32'h0);
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5;
        settle();
        chk("t5_pend1_wb", {31'b0, pend1}, 32'h0);
        chk("t5_rdata1_wb", rdata1, 32'hA5);
        step();
        we = 1'b0;
        settle();
        chk("t5_pend1_clr", {31'b0, pend1}, 32'h0);
        chk("t5_rdata1_reg", rdata1, 32'hA5);

        // T6 set and clear collide on x3: set wins.
        pend_set = 1'b1; pend_addr = 5'd3;
        we = 1'b1; waddr = 5'd3; wdata = 32'h3333_0003;
        step();
        pend_set = 1'b0; we = 1'b0; raddr1 = 5'd3;
        settle();
        chk("t6_pend1", {31'b0, pend1}, 32'h1);
        chk("t6_rdata1", rdata1, 32'h3333_0003);
        // A write to another register must not clear x3.
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        step();
        we = 1'b0;
        settle();
        chk("t6_pend1_kept", {31'b0, pend1}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
